// File: rtl/inst_fetcher_if.sv
// inst_fetcher_if: valid/ready request and response channels between the fetcher and the instruction memory controller.
interface inst_fetcher_if #(
   parameter int MEM_ADDR_WIDTH = 8,
   parameter int MEM_DATA_WIDTH = 16
);
   logic                      fetch_req_rdy;
   logic                      fetch_req_val;
   logic [MEM_ADDR_WIDTH-1:0] fetch_req_addr;
   logic                      fetch_resp_rdy;
   logic                      fetch_resp_val;
   logic [MEM_DATA_WIDTH-1:0] fetch_resp_inst;
   modport master (
      output fetch_req_val, fetch_req_addr, fetch_resp_rdy,
      input  fetch_req_rdy, fetch_resp_val, fetch_resp_inst
   );
   modport slave (
      input  fetch_req_val, fetch_req_addr, fetch_resp_rdy,
      output fetch_req_rdy, fetch_resp_val, fetch_resp_inst
   );
endinterface

// File: rtl/inst_fetcher.sv
// inst_fetcher: latches pc on fetch_en, requests the word, holds it for the decoder, retries on response timeout.
module inst_fetcher #(
   parameter int MEM_ADDR_WIDTH = 8,
   parameter int MEM_DATA_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      fetch_en,
   input  logic [MEM_ADDR_WIDTH-1:0] pc,
   output logic [MEM_DATA_WIDTH-1:0] inst_out,
   output logic                      inst_valid,
   input  logic                      inst_ack,
   inst_fetcher_if.master            bus,
   output logic [1:0]                fetch_state,
   output logic                      timeout_err
);
   typedef enum logic [1:0] {IDLE = 2'd0, REQUEST = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
   state_t     state;
   logic [7:0] cnt;
   assign fetch_state = state;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= IDLE;
         cnt                <= '0;
         inst_out           <= '0;
         inst_valid         <= 1'b0;
         bus.fetch_req_val  <= 1'b0;
         bus.fetch_req_addr <= '0;
         bus.fetch_resp_rdy <= 1'b0;
         timeout_err        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (fetch_en) begin
               bus.fetch_req_addr <= pc;
               bus.fetch_req_val  <= 1'b1;
               state              <= REQUEST;
            end
            REQUEST: if (bus.fetch_req_val && bus.fetch_req_rdy) begin
               bus.fetch_req_val  <= 1'b0;
               bus.fetch_resp_rdy <= 1'b1;
               cnt                <= '0;
               state              <= WAIT;
            end
            // a response in the timeout cycle still completes the fetch
            WAIT: if (bus.fetch_resp_val) begin
               inst_out           <= bus.fetch_resp_inst;
               inst_valid         <= 1'b1;
               bus.fetch_resp_rdy <= 1'b0;
               state              <= DONE;
            end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
               timeout_err        <= 1'b1;
               bus.fetch_resp_rdy <= 1'b0;
               bus.fetch_req_val  <= 1'b1;
               cnt                <= '0;
               state              <= REQUEST;
            end else begin
               cnt <= cnt + 8'd1;
            end
            DONE: if (inst_ack) begin
               inst_valid <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed test-plan scenarios with literal expectations, then random traffic against a phase-level reference model.
module tb_inst_fetcher;
   localparam int AW = 8, DW = 16, TO = 8;
   logic          clk = 0, reset = 0, fetch_en = 0, inst_ack = 0;
   logic [AW-1:0] pc = '0;
   logic [DW-1:0] inst_out;
   logic          inst_valid, timeout_err;
   logic [1:0]    fetch_state;
   int            n_cmp = 0, n_bad = 0;
   inst_fetcher_if #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) bus ();
   inst_fetcher #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc(pc), .inst_out(inst_out),
      .inst_valid(inst_valid), .inst_ack(inst_ack), .bus(bus),
      .fetch_state(fetch_state), .timeout_err(timeout_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk_reset_vals(input string nm);
      chk({nm, " state"}, 32'(fetch_state), 0);
      chk({nm, " inst_out"}, 32'(inst_out), 0);
      chk({nm, " inst_valid"}, 32'(inst_valid), 0);
      chk({nm, " req_val"}, 32'(bus.fetch_req_val), 0);
      chk({nm, " req_addr"}, 32'(bus.fetch_req_addr), 0);
      chk({nm, " resp_rdy"}, 32'(bus.fetch_resp_rdy), 0);
      chk({nm, " timeout_err"}, 32'(timeout_err), 0);
   endtask
   // Reference: phase 0..3 = idle/request/wait/done; outputs follow from the phase.
   int            ph = 0, wc = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_inst = '0;
   logic          m_err = 0;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ph <= 0; wc <= 0; m_addr <= '0; m_inst <= '0; m_err <= 0;
      end else if (ph == 0) begin
         if (fetch_en) begin m_addr <= pc; ph <= 1; end
      end else if (ph == 1) begin
         if (bus.fetch_req_rdy) begin ph <= 2; wc <= 0; end
      end else if (ph == 2) begin
         wc <= wc + 1;
         if (bus.fetch_resp_val) begin m_inst <= bus.fetch_resp_inst; ph <= 3; end
         else if (wc + 1 == TO) begin m_err <= 1; ph <= 1; end
      end else if (inst_ack) begin
         ph <= 0;
      end
   end
   always @(negedge clk) if (!reset) begin
      chk("m.state", 32'(fetch_state), 32'(ph));
      chk("m.req_val", 32'(bus.fetch_req_val), 32'(ph == 1));
      chk("m.resp_rdy", 32'(bus.fetch_resp_rdy), 32'(ph == 2));
      chk("m.inst_valid", 32'(inst_valid), 32'(ph == 3));
      chk("m.req_addr", 32'(bus.fetch_req_addr), 32'(m_addr));
      chk("m.inst_out", 32'(inst_out), 32'(m_inst));
      chk("m.timeout_err", 32'(timeout_err), 32'(m_err));
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
      $fatal(1);
   end
   initial begin
      bus.fetch_req_rdy = 0; bus.fetch_resp_val = 0; bus.fetch_resp_inst = '0;
      reset = 1;
      #3 chk_reset_vals("reset");
      step(2);
      reset = 0;
      // basic fetch with minimum latency
      pc = 8'h10; fetch_en = 1; bus.fetch_req_rdy = 1;
      step(1);
      fetch_en = 0;
      chk("t1 state req", 32'(fetch_state), 1);
      chk("t1 addr", 32'(bus.fetch_req_addr), 32'h10);
      step(1);
      chk("t1 state wait", 32'(fetch_state), 2);
      bus.fetch_resp_val = 1; bus.fetch_resp_inst = 16'hBEEF;
      step(1);
      bus.fetch_resp_val = 0;
      chk("t1 valid 4th cycle", 32'(inst_valid), 1);
      chk("t1 inst", 32'(inst_out), 32'hBEEF);
      chk("t1 err", 32'(timeout_err), 0);
      inst_ack = 1;
      step(1);
      inst_ack = 0;
      chk("t1 valid cleared", 32'(inst_valid), 0);
      chk("t1 inst kept", 32'(inst_out), 32'hBEEF);
      // request held while controller not ready; pc change ignored
      pc = 8'h10; fetch_en = 1; bus.fetch_req_rdy = 0;
      step(1);
      fetch_en = 0; pc = 8'h22;
      for (int i = 0; i < 5; i++) begin
         chk("t2 held state", 32'(fetch_state), 1);
         chk("t2 held addr", 32'(bus.fetch_req_addr), 32'h10);
         chk("t2 held val", 32'(bus.fetch_req_val), 1);
         step(1);
      end
      bus.fetch_req_rdy = 1;
      step(1);
      chk("t2 wait", 32'(fetch_state), 2);
      // single-cycle response pulse in the third WAIT cycle, long hold in DONE
      step(2);
      bus.fetch_resp_val = 1; bus.fetch_resp_inst = 16'h1234;
      step(1);
      bus.fetch_resp_val = 0;
      chk("t3 inst", 32'(inst_out), 32'h1234);
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("t3 hold valid", 32'(inst_valid), 1);
      end
      inst_ack = 1;
      step(1);
      inst_ack = 0;
      chk("t3 cleared", 32'(inst_valid), 0);
      chk("t3 idle", 32'(fetch_state), 0);
      // response in the last WAIT cycle beats the timeout
      pc = 8'h5A; fetch_en = 1;
      step(2);
      fetch_en = 0;
      step(TO - 1);
      bus.fetch_resp_val = 1; bus.fetch_resp_inst = 16'h0F0F;
      step(1);
      bus.fetch_resp_val = 0;
      chk("t4 resp wins state", 32'(fetch_state), 3);
      chk("t4 resp wins err", 32'(timeout_err), 0);
      inst_ack = 1;
      step(1);
      inst_ack = 0;
      // timeout and retry
      pc = 8'h33; fetch_en = 1;
      step(2);
      fetch_en = 0;
      step(TO - 1);
      chk("t5 still wait", 32'(fetch_state), 2);
      step(1);
      chk("t5 retry state", 32'(fetch_state), 1);
      chk("t5 retry val", 32'(bus.fetch_req_val), 1);
      chk("t5 retry addr", 32'(bus.fetch_req_addr), 32'h33);
      chk("t5 err", 32'(timeout_err), 1);
      step(1);
      bus.fetch_resp_val = 1; bus.fetch_resp_inst = 16'h00FF;
      step(1);
      bus.fetch_resp_val = 0;
      chk("t5 inst", 32'(inst_out), 32'h00FF);
      chk("t5 err sticky", 32'(timeout_err), 1);
      inst_ack = 1;
      step(1);
      inst_ack = 0;
      // asynchronous reset while waiting
      pc = 8'h44; fetch_en = 1;
      step(2);
      fetch_en = 0;
      #2 reset = 1;
      #1 chk_reset_vals("async");
      step(1);
      reset = 0;
      bus.fetch_resp_val = 1; bus.fetch_resp_inst = 16'hDEAD;
      step(1);
      bus.fetch_resp_val = 0;
      chk("t6 ignored state", 32'(fetch_state), 0);
      chk("t6 ignored inst", 32'(inst_out), 0);
      // fetch_en held through DONE: new fetch only from IDLE with that cycle's pc
      pc = 8'h40; fetch_en = 1;
      step(2);
      bus.fetch_resp_val = 1; bus.fetch_resp_inst = 16'hAAAA;
      step(1);
      bus.fetch_resp_val = 0; pc = 8'h11; inst_ack = 1;
      step(1);
      chk("t7 back to idle", 32'(fetch_state), 0);
      inst_ack = 0;
      step(1);
      fetch_en = 0;
      chk("t7 refetch state", 32'(fetch_state), 1);
      chk("t7 refetch addr", 32'(bus.fetch_req_addr), 32'h11);
      // random traffic, model-checked every cycle
      for (int i = 0; i < 4000; i++) begin
         fetch_en = ($urandom_range(0, 3) == 0);
         pc = 8'($urandom);
         bus.fetch_req_rdy = ($urandom_range(0, 1) == 0);
         bus.fetch_resp_val = ($urandom_range(0, 9) == 0);
         bus.fetch_resp_inst = 16'($urandom);
         inst_ack = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1;
            #1 chk_reset_vals("rand async");
            step(1);
            reset = 0;
         end else begin
            step(1);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
